// File: rtl/dbg_jtag_sysclk_cmd_bridge_if.sv
// rtl/dbg_jtag_sysclk_cmd_bridge_if.sv - command handshake bundle between the debug bridge and the debug core
interface dbg_jtag_sysclk_cmd_bridge_if #(
    parameter int DATA_W = 38,
    parameter int IR_W   = 2
);
    logic [DATA_W-1:0]    jdo;
    logic [IR_W-1:0]      cmd_ir;
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [2**IR_W-1:0]   take_action;
    logic [2**IR_W-1:0]   take_no_action;

    modport master (
        output jdo, cmd_ir, cmd_valid, take_action, take_no_action,
        input  cmd_ready
    );

    modport slave (
        input  jdo, cmd_ir, cmd_valid, take_action, take_no_action,
        output cmd_ready
    );
endinterface

// File: rtl/dbg_jtag_sysclk_cmd_bridge.sv
// rtl/dbg_jtag_sysclk_cmd_bridge.sv - sysclk side of the JTAG debug slave: update-DR sync, command FIFO, action decode (option: DBG_BRIDGE_DROP_CNT_EN)
module dbg_jtag_sysclk_cmd_bridge #(
    parameter int DATA_W      = 38,
    parameter int IR_W        = 2,
    parameter int ACT_BIT     = 34,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          upd_toggle,
    input  logic [IR_W-1:0]               ir_in,
    input  logic [DATA_W-1:0]             sr,
    dbg_jtag_sysclk_cmd_bridge_if.master  cmd,
    output logic                          overflow,
    input  logic                          ovf_clr,
    output logic [7:0]                    drop_count
);
    localparam int AW    = $clog2(DEPTH);
    localparam int EW    = IR_W + DATA_W;
    localparam int ARM_W = $clog2(SYNC_STAGES + 2);
    localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES + 1);
    localparam logic [AW:0]      FULL     = (AW + 1)'(DEPTH);

    logic [SYNC_STAGES:1] s;
    logic                 h;
    logic [ARM_W-1:0]     arm_cnt;
    logic                 armed;
    logic                 upd_pulse;

    logic [EW-1:0]        mem [DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW:0]          count;
    logic [EW-1:0]        last_q;
    logic [EW-1:0]        head;
    logic                 full;
    logic                 pop;
    logic                 push;
    logic                 drop;

    // Toggle synchroniser, edge-history flop and post-reset arming delay
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s       <= '0;
            h       <= 1'b0;
            arm_cnt <= '0;
        end else begin
            s <= {s[SYNC_STAGES-1:1], upd_toggle};
            h <= s[SYNC_STAGES];
            if (!armed) begin
                arm_cnt <= arm_cnt + ARM_W'(1);
            end
        end
    end

    // h keeps tracking while unarmed so a level held across reset never becomes a pulse
    assign armed     = (arm_cnt == ARM_DONE);
    assign upd_pulse = (s[SYNC_STAGES] ^ h) & armed;

    assign full = (count == FULL);
    assign pop  = cmd.cmd_valid & cmd.cmd_ready;
    assign push = upd_pulse & (!full | pop);
    assign drop = upd_pulse & full & !pop;

    // Command storage; contents are only visible through the pointers, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {ir_in, sr};
        end
    end

    // Pointers, occupancy and the last-popped entry shown while empty
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            last_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                last_q <= mem[rd_ptr];
            end
            if (push && !pop) begin
                count <= count + (AW + 1)'(1);
            end else if (pop && !push) begin
                count <= count - (AW + 1)'(1);
            end
        end
    end

    assign head          = (count != '0) ? mem[rd_ptr] : last_q;
    assign cmd.jdo       = head[DATA_W-1:0];
    assign cmd.cmd_ir    = head[EW-1:DATA_W];
    assign cmd.cmd_valid = (count != '0);

    // One-hot action decode, live only during the handshake cycle
    always_comb begin
        cmd.take_action    = '0;
        cmd.take_no_action = '0;
        if (pop) begin
            if (cmd.jdo[ACT_BIT]) begin
                cmd.take_action[cmd.cmd_ir] = 1'b1;
            end else begin
                cmd.take_no_action[cmd.cmd_ir] = 1'b1;
            end
        end
    end

    // Sticky overflow flag; a drop beats a same-cycle clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

`ifdef DBG_BRIDGE_DROP_CNT_EN
    // Saturating drop counter; a drop with a same-cycle clear restarts at one
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_count <= 8'd0;
        end else if (drop) begin
            if (ovf_clr) begin
                drop_count <= 8'd1;
            end else if (drop_count != 8'hff) begin
                drop_count <= drop_count + 8'd1;
            end
        end else if (ovf_clr) begin
            drop_count <= 8'd0;
        end
    end
`else
    assign drop_count = 8'd0;
`endif

endmodule

// File: tb/tb_dbg_jtag_sysclk_cmd_bridge.sv
// tb/tb_dbg_jtag_sysclk_cmd_bridge.sv - randomized scoreboard bench for dbg_jtag_sysclk_cmd_bridge
module tb_dbg_jtag_sysclk_cmd_bridge;
    localparam int N     = 2;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        upd_toggle = 1'b0;
    logic        ovf_clr = 1'b0;
    logic [1:0]  ir_in = '0;
    logic [37:0] sr = '0;
    logic        overflow;
    logic [7:0]  drop_count;

    dbg_jtag_sysclk_cmd_bridge_if #(.DATA_W(38), .IR_W(2)) bus ();

    dbg_jtag_sysclk_cmd_bridge #(
        .DATA_W(38), .IR_W(2), .ACT_BIT(34), .DEPTH(DEPTH), .SYNC_STAGES(N)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .upd_toggle (upd_toggle),
        .ir_in      (ir_in),
        .sr         (sr),
        .cmd        (bus),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  ir;
        logic [37:0] d;
    } cmd_t;

    cmd_t mq[$];
    cmd_t last_c;
    cmd_t pend_c;
    int   pend;
    bit   m_ovf;
    int   m_dcnt;
    int   errors = 0;
    int   checks = 0;

`ifdef DBG_BRIDGE_DROP_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    function automatic logic [7:0] exp_cnt(input int v);
        return CNT_EN ? 8'(v) : 8'd0;
    endfunction

    function automatic logic [37:0] rnd38();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[37:0];
    endfunction

    // One clock cycle: drive, compare against the model at mid-cycle, advance the model at the edge
    task automatic step(input bit rdy, input bit clr);
        cmd_t       hd;
        logic [3:0] ea;
        logic [3:0] ena;
        bit         popping;
        bit         was_full;
        bit         dropped;
        bus.cmd_ready = rdy;
        ovf_clr = clr;
        #1;
        hd = (mq.size() != 0) ? mq[0] : last_c;
        popping = (mq.size() != 0) && rdy;
        was_full = (mq.size() == DEPTH);
        ea = '0;
        ena = '0;
        if (popping) begin
            if (hd.d[34]) ea[hd.ir] = 1'b1;
            else ena[hd.ir] = 1'b1;
        end
        checks += 7;
        if (bus.cmd_valid !== (mq.size() != 0)) begin
            errors++; $display("FAIL cmd_valid @%0t: got %0b expected %0b", $time, bus.cmd_valid, mq.size() != 0);
        end
        if (bus.jdo !== hd.d) begin
            errors++; $display("FAIL jdo @%0t: got %0h expected %0h", $time, bus.jdo, hd.d);
        end
        if (bus.cmd_ir !== hd.ir) begin
            errors++; $display("FAIL cmd_ir @%0t: got %0d expected %0d", $time, bus.cmd_ir, hd.ir);
        end
        if (bus.take_action !== ea) begin
            errors++; $display("FAIL take_action @%0t: got %b expected %b", $time, bus.take_action, ea);
        end
        if (bus.take_no_action !== ena) begin
            errors++; $display("FAIL take_no_action @%0t: got %b expected %b", $time, bus.take_no_action, ena);
        end
        if (overflow !== m_ovf) begin
            errors++; $display("FAIL overflow @%0t: got %0b expected %0b", $time, overflow, m_ovf);
        end
        if (drop_count !== exp_cnt(m_dcnt)) begin
            errors++; $display("FAIL drop_count @%0t: got %0d expected %0d", $time, drop_count, exp_cnt(m_dcnt));
        end
        @(posedge clk);
        dropped = 1'b0;
        if (popping) last_c = mq.pop_front();
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                if (was_full && !popping) begin
                    dropped = 1'b1;
                    m_ovf = 1'b1;
                    m_dcnt = clr ? 1 : ((m_dcnt < 255) ? m_dcnt + 1 : 255);
                end else begin
                    mq.push_back(pend_c);
                end
            end
        end
        if (!dropped && clr) begin
            m_ovf = 1'b0;
            m_dcnt = 0;
        end
        @(negedge clk);
    endtask

    // An update-DR on the TCK side: new IR/SR then a toggle; arrives on the (N+1)th following edge
    task automatic send(input logic [1:0] ir, input logic [37:0] d);
        ir_in = ir;
        sr = d;
        upd_toggle = ~upd_toggle;
        pend_c = '{ir: ir, d: d};
        pend = N + 1;
    endtask

    task automatic do_reset(input logic tog_level);
        reset = 1'b1;
        upd_toggle = tog_level;
        #1;
        mq.delete();
        last_c = '0;
        pend = 0;
        m_ovf = 1'b0;
        m_dcnt = 0;
        checks += 6;
        if (bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_cmd_valid: got %0b expected 0", bus.cmd_valid); end
        if (bus.jdo !== '0) begin errors++; $display("FAIL reset_jdo: got %0h expected 0", bus.jdo); end
        if (bus.cmd_ir !== '0) begin errors++; $display("FAIL reset_cmd_ir: got %0d expected 0", bus.cmd_ir); end
        if ((bus.take_action | bus.take_no_action) !== 4'b0) begin
            errors++; $display("FAIL reset_take: got %b/%b expected 0", bus.take_action, bus.take_no_action);
        end
        if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %0b expected 0", overflow); end
        if (drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop_count: got %0d expected 0", drop_count); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (N + 3) step(1'b1, 1'b0);
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        send(2'd1, rnd38());
        repeat (N + 2) step(1'b0, 1'b0);
        send(2'd3, rnd38());
        repeat (N + 2) step(1'b0, 1'b0);
        do_reset(upd_toggle);
    endtask

    task automatic test_single();
        logic [37:0] d;
        repeat (5) step(1'b1, 1'b0);
        d = rnd38();
        d[34] = 1'b1;
        send(2'd2, d);
        repeat (N) step(1'b1, 1'b0);
        #1;
        checks++;
        if (bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %0b expected 0", bus.cmd_valid); end
        step(1'b1, 1'b0);
        #1;
        checks += 4;
        if (bus.cmd_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %0b expected 1", bus.cmd_valid); end
        if (bus.take_action !== 4'b0100) begin errors++; $display("FAIL single_take_action: got %b expected 0100", bus.take_action); end
        if (bus.take_no_action !== 4'b0000) begin errors++; $display("FAIL single_take_no_action: got %b expected 0000", bus.take_no_action); end
        if (bus.jdo !== d) begin errors++; $display("FAIL single_jdo: got %0h expected %0h", bus.jdo, d); end
        step(1'b1, 1'b0);
        #1;
        checks++;
        if (bus.take_action !== 4'b0000) begin errors++; $display("FAIL single_pulse_width: got %b expected 0000", bus.take_action); end
        step(1'b1, 1'b0);
    endtask

    task automatic test_no_action();
        logic [37:0] d;
        d = rnd38();
        d[34] = 1'b0;
        send(2'd0, d);
        repeat (N + 1) step(1'b1, 1'b0);
        #1;
        checks += 2;
        if (bus.take_no_action !== 4'b0001) begin errors++; $display("FAIL noact_take_no_action: got %b expected 0001", bus.take_no_action); end
        if (bus.take_action !== 4'b0000) begin errors++; $display("FAIL noact_take_action: got %b expected 0000", bus.take_action); end
        repeat (2) step(1'b1, 1'b0);
    endtask

    task automatic test_overflow();
        cmd_t sent [5];
        for (int k = 0; k < 5; k++) begin
            sent[k] = '{ir: 2'($urandom_range(0, 3)), d: rnd38()};
            send(sent[k].ir, sent[k].d);
            repeat (N + 2) step(1'b0, 1'b0);
        end
        checks += 3;
        if (bus.cmd_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid: got %0b expected 1", bus.cmd_valid); end
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %0b expected 1", overflow); end
        if (drop_count !== exp_cnt(1)) begin errors++; $display("FAIL ovf_drop_count: got %0d expected %0d", drop_count, exp_cnt(1)); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (bus.jdo !== sent[k].d) begin errors++; $display("FAIL ovf_order%0d: got %0h expected %0h", k, bus.jdo, sent[k].d); end
            step(1'b1, 1'b0);
        end
        checks++;
        if (bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained: got %0b expected 0", bus.cmd_valid); end
        step(1'b0, 1'b1);
        checks += 2;
        if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %0b expected 0", overflow); end
        if (drop_count !== 8'd0) begin errors++; $display("FAIL ovf_clear_count: got %0d expected 0", drop_count); end
    endtask

    task automatic test_full_push_pop();
        int n;
        for (int k = 0; k < 4; k++) begin
            send(2'($urandom_range(0, 3)), rnd38());
            repeat (N + 2) step(1'b0, 1'b0);
        end
        send(2'($urandom_range(0, 3)), rnd38());
        repeat (N) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL fullpp_overflow: got %0b expected 0", overflow); end
        n = 0;
        repeat (8) begin
            if (bus.cmd_valid === 1'b1) n++;
            step(1'b1, 1'b0);
        end
        checks++;
        if (n != 4) begin errors++; $display("FAIL fullpp_count: got %0d expected 4", n); end
    endtask

    task automatic test_reset_toggle_high();
        int n;
        do_reset(1'b1);
        n = 0;
        repeat (8) begin
            if (bus.cmd_valid === 1'b1) n++;
            step(1'b1, 1'b0);
        end
        checks++;
        if (n != 0) begin errors++; $display("FAIL rsthigh_spurious: got %0d expected 0", n); end
        send(2'd1, rnd38());
        n = 0;
        repeat (N + 5) begin
            if (bus.cmd_valid === 1'b1) n++;
            step(1'b1, 1'b0);
        end
        checks++;
        if (n != 1) begin errors++; $display("FAIL rsthigh_one_cmd: got %0d expected 1", n); end
    endtask

    task automatic test_saturation();
        step(1'b0, 1'b1);
        for (int k = 0; k < 304; k++) begin
            send(2'($urandom_range(0, 3)), rnd38());
            repeat (N + 2) step(1'b0, 1'b0);
        end
        checks += 2;
        if (drop_count !== exp_cnt(255)) begin errors++; $display("FAIL sat_count: got %0d expected %0d", drop_count, exp_cnt(255)); end
        if (overflow !== 1'b1) begin errors++; $display("FAIL sat_overflow: got %0b expected 1", overflow); end
        send(2'd3, rnd38());
        repeat (N) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        #1;
        checks += 2;
        if (overflow !== 1'b1) begin errors++; $display("FAIL clr_drop_overflow: got %0b expected 1", overflow); end
        if (drop_count !== exp_cnt(1)) begin errors++; $display("FAIL clr_drop_count: got %0d expected %0d", drop_count, exp_cnt(1)); end
        step(1'b0, 1'b1);
        #1;
        checks += 2;
        if (overflow !== 1'b0) begin errors++; $display("FAIL sat_clear: got %0b expected 0", overflow); end
        if (drop_count !== 8'd0) begin errors++; $display("FAIL sat_clear_count: got %0d expected 0", drop_count); end
        repeat (6) step(1'b1, 1'b0);
    endtask

    task automatic test_random();
        int gap;
        repeat (60) begin
            send(2'($urandom_range(0, 3)), rnd38());
            gap = N + 2 + $urandom_range(0, 3);
            repeat (gap) step($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0);
        end
        repeat (10) step(1'b1, 1'b0);
    endtask

    initial begin
        bus.cmd_ready = 1'b0;
        pend = 0;
        last_c = '0;
        m_ovf = 1'b0;
        m_dcnt = 0;
        @(negedge clk);
        test_reset();
        test_single();
        test_no_action();
        test_overflow();
        test_full_push_pop();
        test_reset_toggle_high();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
